// File: rtl/mips_pkg.sv
// Decode constants and hazard FSM encoding shared by the issue-side hazard logic.
package mips_pkg;
  localparam logic [4:0] OP_LW = 5'b10000;
  localparam logic [4:0] OP_SW = 5'b10001;

  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 14;
  localparam int DST_MSB = 13;
  localparam int DST_LSB = 11;
  localparam int A_MSB   = 10;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 5;

  localparam logic [2:0] REG_ZERO = 3'd0;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_FLUSH    = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the hazard unit: decode/execute instructions, memory
// handshake and the resulting enables, flushes and statistics.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [18:0]      IF_ID_instruction;
  logic [18:0]      ID_EX_instruction;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_ID_instruction, ID_EX_instruction, ex_redirect, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
    input  mem_stall, stall_count, flush_count
  );

  modport slave (
    input  IF_ID_instruction, ID_EX_instruction, ex_redirect, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
    output mem_stall, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_src_decode.sv
// Which register fields of a decode-stage instruction are actually read.
module hazard_src_decode
  import mips_pkg::*;
(
  input  logic [18:0] instr_i,
  output logic        use_a_o,
  output logic        use_b_o,
  output logic        use_dst_o
);
  logic [4:0] op;
  logic       unused_fields;

  assign op            = instr_i[OP_MSB:OP_LSB];
  assign unused_fields = ^instr_i[DST_MSB:0];

  // op[4]=0 is the ALU group; op[3] selects its immediate form
  assign use_a_o   = !op[4] || (op == OP_LW) || (op == OP_SW);
  assign use_b_o   = !op[4] && !op[3];
  assign use_dst_o = (op == OP_SW);
endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use, redirect and data-memory wait handling for the issue stages,
// with saturating stall/flush statistics.
module hazard_stall_unit
  import mips_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_unit_if.slave hz
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       use_a, use_b, use_dst, lu;
  logic       lu_stall, redirect_acc;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, mem_stall;
  logic [4:0] ex_op;
  logic [2:0] ex_dst, id_dst, id_a, id_b;
  logic       unused_ex;

  hazard_src_decode u_src_decode (
    .instr_i   (hz.IF_ID_instruction),
    .use_a_o   (use_a),
    .use_b_o   (use_b),
    .use_dst_o (use_dst)
  );

  assign ex_op     = hz.ID_EX_instruction[OP_MSB:OP_LSB];
  assign ex_dst    = hz.ID_EX_instruction[DST_MSB:DST_LSB];
  assign unused_ex = ^hz.ID_EX_instruction[A_MSB:0];
  assign id_dst    = hz.IF_ID_instruction[DST_MSB:DST_LSB];
  assign id_a      = hz.IF_ID_instruction[A_MSB:A_LSB];
  assign id_b      = hz.IF_ID_instruction[B_MSB:B_LSB];

  assign lu = (ex_op == OP_LW) && (ex_dst != REG_ZERO) &&
              ((use_a && id_a == ex_dst) || (use_b && id_b == ex_dst) ||
               (use_dst && id_dst == ex_dst));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_stall    = 1'b0;
    lu_stall     = 1'b0;
    redirect_acc = 1'b0;
    if (hz.mem_req && !hz.mem_ready) begin
      // whole pipe freezes; any pending flush count is simply held
      mem_stall   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = HZ_MEM_WAIT;
    end else if (hz.ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      redirect_acc = 1'b1;
      fcnt_d       = FLUSH_LOAD;
      state_d      = (FLUSH_LOAD != 2'd0) ? HZ_FLUSH : HZ_RUN;
    end else if (state_q == HZ_FLUSH) begin
      if_id_flush = 1'b1;
      fcnt_d      = fcnt_q - 2'd1;
      state_d     = (fcnt_q == 2'd1) ? HZ_RUN : HZ_FLUSH;
    end else begin
      // RUN, or the release cycle of MEM_WAIT which resumes any held flush
      if (lu) begin
        lu_stall     = 1'b1;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      state_d = (fcnt_q != 2'd0) ? HZ_FLUSH : HZ_RUN;
    end
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_stall    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      fcnt_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if ((lu_stall || mem_stall) && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_acc && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.mem_stall    = mem_stall;
  assign hz.stall_count  = stall_cnt_q;
  assign hz.flush_count  = flush_cnt_q;
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Issue-side companion to the EX-stage forwarding logic: it resolves the hazards that forwarding cannot cover.
- Sits between the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards, branch/jump redirects and data-memory wait states.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF-ID/ID-EX flushes; keeps saturating stall/flush statistics.

Parameters:
- FLUSH_CYCLES, 2: cycles the front end is flushed after a taken redirect (1..3).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- IF_ID_instruction  in  19  instruction currently in decode
- ID_EX_instruction  in  19  instruction currently in execute
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  MEM stage is accessing data memory (lw/sw)
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- id_ex_bubble  out  1  load NOP into ID/EX instead of decoded instruction
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  clear ID/EX to NOP
- mem_stall  out  1  freeze EX/MEM and MEM/WB registers
- stall_count  out  CNT_W  load-use plus memory stall cycles, saturating
- flush_count  out  CNT_W  redirects accepted, saturating

Behaviour:
- Field aliases: op[18:14], DST[13:11], A[10:8], B[7:5]. ALU type is op[18]=0; immediate form is op[17]=1; LW is 10000; SW is 10001.
- Source use in decode:
  - A is used by ALU, LW and SW.
  - B is used by ALU only when not immediate.
  - DST is used as the store-data register by SW.
- Load-use hazard (lu):
  - ID_EX op==LW, ID_EX DST!=0, and any used IF_ID source equals ID_EX DST.
  - Register 0 never hazards.
- FSM states: RUN, FLUSH, MEM_WAIT. The state register and a 2-bit flush counter update on the clk rising edge.
- Outputs are combinational from the state and the current inputs. Defaults: pc_write=1, if_id_write=1, all other control outputs 0.
- Per-cycle priority: memory wait > redirect > load-use.
  - mem_req & !mem_ready (any state):
    - mem_stall=1, pc_write=0, if_id_write=0.
    - No bubble and no flush; the whole pipe freezes.
    - Next state is MEM_WAIT; a pending redirect/flush count is held.
  - MEM_WAIT & mem_ready: outputs follow the RUN rules this cycle; next state is RUN, or FLUSH if counter>0.
  - RUN & ex_redirect:
    - if_id_flush=1, id_ex_flush=1, pc_write=1 (PC takes the target).
    - Counter loads FLUSH_CYCLES-1; next state is FLUSH if that is >0, else RUN.
    - flush_count increments.
    - lu in the same cycle is ignored.
  - FLUSH: if_id_flush=1, counter decrements, and the state returns to RUN when it reaches 0. A new ex_redirect reloads the counter.
  - RUN & lu (no redirect): pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly one cycle. The next cycle the LW is in MEM, so no lu remains.
- stall_count increments on every cycle with lu or mem_stall asserted. Both counters saturate at all-ones and never wrap.
- While rst_n=0 at the clock edge:
  - State goes to RUN, counters and the flush counter clear.
  - Combinational outputs are forced to pc_write=0, if_id_write=0, id_ex_bubble=1, flushes=0, mem_stall=0 while rst_n is low.
- Reset mid-MEM_WAIT or mid-FLUSH abandons the operation immediately.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (OP_LW=5'b10000, OP_SW=5'b10001).
  - Field-slice localparams (DST/A/B bit ranges), the REG_ZERO constant and the hazard FSM state enum.
- Sub-module hazard_src_decode: combinational use-A/use-B/use-DST flags from a 19-bit instruction.
- FSM, counters and priority logic stay in the top.

Test Plan:
1. LW DST=3 in ID_EX; ALU reg-reg A=3 in IF_ID -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1; next cycle all defaults.
2. LW DST=0 in ID_EX; consumer reads A=0 -> no stall. Immediate ALU with B field=3 after LW DST=3 -> no stall.
3. SW whose DST=5 follows LW DST=5 -> bubble for one cycle. SW A=5 also stalls.
4. ex_redirect with FLUSH_CYCLES=2 -> cycle 0: both flushes=1; cycle 1: if_id_flush only; cycle 2: RUN. flush_count=1. Concurrent lu in cycle 0 produces no bubble.
5. mem_req=1, mem_ready=0 for 3 cycles, then ready -> mem_stall=1 and PC frozen for 3 cycles; stall_count +3; RUN after ready.
6. rst_n=0 during FLUSH with counter=1 -> next cycle is RUN with counters 0. Preloading stall_count to 0xFFFF and stalling again -> it stays 0xFFFF.
